rc4_prga_xor: RTL and testbench
===============================

Name: rc4_prga_xor

Overview:
- RC4 keystream generator (PRGA) plus XOR datapath.
- Counterpart of the key-scheduling stage: it takes the finished permuted S-box from the key scheduler and encrypts or decrypts a byte stream with it. RC4 is symmetric, so the same block does both.
- Sits between the key-scheduling block and the byte stream source/sink.
- Uses a valid/ready handshake on both data sides.

Parameters:
DROP_N, 0, number of initial keystream bytes generated and discarded before the first data byte (RC4-drop[n]); legal range 0..65535.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
sbox_wr_en  input  1  S-box load strobe; write accepted only in EMPTY
sbox_wr_addr  input  8  S-box load index
sbox_wr_data  input  8  S-box load value
sbox_done  input  1  one-cycle pulse: S-box load complete
sbox_clear  input  1  one-cycle pulse: abandon current key, return to EMPTY
data_in  input  8  plaintext/ciphertext byte
data_in_valid  input  1  data_in valid
data_in_ready  output  1  block accepts data_in this cycle
data_out  output  8  data_in XOR keystream byte
data_out_valid  output  1  data_out valid
data_out_ready  input  1  sink accepts data_out
key_ready  output  1  S-box loaded and drop phase finished

Behaviour:
- Storage:
  - 256x8 S array; indices i and j (8-bit, wrap mod 256).
  - si/sj capture registers; din_q input capture register.
  - 16-bit drop counter.
  - All index arithmetic is 8-bit, wrapping mod 256.
- States: EMPTY, DROP1, DROP2, DROP3, WAIT_IN, G1, G2, G3, HOLD.
- Reset (async, rst=1):
  - state=EMPTY; i=j=0; drop counter=0; S[m]=m for all m.
  - data_out=0; data_out_valid=0; data_in_ready=0; key_ready=0.
- EMPTY:
  - sbox_wr_en writes S[sbox_wr_addr]=sbox_wr_data.
  - On sbox_done: go to DROP1 if DROP_N>0, else WAIT_IN.
  - If sbox_wr_en and sbox_done occur in the same cycle, the write is performed and the transition is taken.
- Outside EMPTY: sbox_wr_en and sbox_done are ignored.
- Generation step (shared by drop and data paths; DROPk mirrors Gk):
  - G1: i<=i+1; si<=S[i+1]; j<=j+S[i+1].
  - G2: sj<=S[j]; S[i]<=S[j]; S[j]<=si (swap). i==j is legal and leaves S unchanged.
  - G3: K=S[(si+sj) mod 256], read from the post-swap array.
- Drop phase:
  - DROP3 increments the drop counter.
  - After DROP3: go to WAIT_IN when count==DROP_N, else DROP1.
  - K is discarded.
- WAIT_IN:
  - data_in_ready=1 (combinational from state).
  - On data_in_valid: din_q<=data_in, go to G1.
- G3 data path: data_out<=din_q^K; data_out_valid<=1; go to HOLD.
- HOLD:
  - data_out and data_out_valid stay stable until data_out_ready.
  - On data_out_ready=1: data_out_valid<=0; go to WAIT_IN.
  - data_in_ready=0 in HOLD; no skid buffer.
- Latency and throughput:
  - The accepting edge is edge 1; data_out_valid is high after edge 4.
  - Maximum throughput is one byte per 5 cycles with data_out_ready tied high.
- key_ready=1 in WAIT_IN, G1..G3 and HOLD; 0 otherwise.
- sbox_clear:
  - Highest priority, any state.
  - Next state is EMPTY; i=j=0; drop counter=0; data_out_valid=0.
  - Any in-flight or held byte is discarded.
  - S keeps its contents until rewritten.
- Reset mid-operation: same as sbox_clear, and S returns to identity.
- Stream continuity: i and j persist across bytes. The keystream continues until sbox_clear or reset, with no rekey per byte.

Test Plan:
- Reset then check: outputs all 0; key_ready=0; data_in_ready=0. Assert rst mid-G2 -> same values on the next cycle.
- Load the S-box for key "Key" (computed by the bench model), DROP_N=0, feed "Plaintext" with data_out_ready=1 -> data_out = BB F3 16 E8 D9 40 AF 0A D3. Each valid rises exactly 3 cycles after the accepting cycle.
- Key "Secret", feed "Attack at dawn" -> 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5. Feed that ciphertext back after sbox_clear and reload -> original plaintext.
- Backpressure: hold data_out_ready=0 for 10 cycles during HOLD -> data_out stable, data_in_ready=0, no byte lost. The output sequence equals the no-stall run.
- DROP_N=3, key "Key", all-zero input -> key_ready rises 9 cycles after sbox_done; the first output equals keystream byte 4 (0x81).
- sbox_wr_en with no sbox_done while in WAIT_IN -> S unchanged, output stream unaffected. Issue sbox_clear in HOLD -> data_out_valid=0 next cycle, state EMPTY, key_ready=0.

Source files
------------

// File: rtl/rc4_prga_xor_if.sv
// Byte-stream and S-box load signals of the RC4 keystream/XOR block.
interface rc4_prga_xor_if;
    logic       sbox_wr_en;
    logic [7:0] sbox_wr_addr;
    logic [7:0] sbox_wr_data;
    logic       sbox_done;
    logic       sbox_clear;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       key_ready;

    modport master (
        output sbox_wr_en, sbox_wr_addr, sbox_wr_data, sbox_done, sbox_clear,
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid, key_ready
    );

    modport slave (
        input  sbox_wr_en, sbox_wr_addr, sbox_wr_data, sbox_done, sbox_clear,
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, key_ready
    );
endinterface

// File: rtl/rc4_prga_xor.sv
// RC4 keystream generator (optional drop[n]) XORed onto a byte stream.
// Latency: output valid 3 cycles after the accepting edge; one byte per 5 cycles.
// Backpressure: result held until data_out_ready; no new input accepted meanwhile.
module rc4_prga_xor #(
    parameter int DROP_N = 0
) (
    input logic            clk,
    input logic            rst,
    rc4_prga_xor_if.slave  bus
);
    typedef enum logic [3:0] {
        EMPTY, DROP1, DROP2, DROP3, WAIT_IN, G1, G2, G3, HOLD
    } state_t;

    localparam logic [15:0] DROP_LIM = 16'(DROP_N);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  s_mem [256];
    logic [7:0]  i_idx;
    logic [7:0]  j_idx;
    logic [7:0]  si;
    logic [7:0]  sj;
    logic [7:0]  din_q;
    logic [15:0] drop_cnt;
    logic [7:0]  data_out_q;
    logic        data_out_valid_q;
    logic        in_rdy;
    logic        key_rdy;

    logic [7:0]  i_inc;
    logic [7:0]  s_at_inc;
    logic [7:0]  s_at_j;
    logic [7:0]  k_idx;

    assign i_inc    = i_idx + 8'd1;
    assign s_at_inc = s_mem[i_inc];
    assign s_at_j   = s_mem[j_idx];
    assign k_idx    = si + sj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        key_rdy   = 1'b0;
        case (state)
            EMPTY:   if (bus.sbox_done) state_nxt = (DROP_N > 0) ? DROP1 : WAIT_IN;
            DROP1:   state_nxt = DROP2;
            DROP2:   state_nxt = DROP3;
            DROP3:   state_nxt = (drop_cnt + 16'd1 == DROP_LIM) ? WAIT_IN : DROP1;
            WAIT_IN: begin
                in_rdy  = 1'b1;
                key_rdy = 1'b1;
                if (bus.data_in_valid) state_nxt = G1;
            end
            G1:      begin key_rdy = 1'b1; state_nxt = G2; end
            G2:      begin key_rdy = 1'b1; state_nxt = G3; end
            G3:      begin key_rdy = 1'b1; state_nxt = HOLD; end
            HOLD:    begin
                key_rdy = 1'b1;
                if (bus.data_out_ready) state_nxt = WAIT_IN;
            end
            default: state_nxt = EMPTY;
        endcase
        // Abandoning the key overrides everything, including a pending handshake.
        if (bus.sbox_clear) begin
            state_nxt = EMPTY;
            in_rdy    = 1'b0;
        end
        if (bus.sbox_clear && state == EMPTY) key_rdy = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_idx            <= '0;
            j_idx            <= '0;
            si               <= '0;
            sj               <= '0;
            din_q            <= '0;
            drop_cnt         <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            for (int m = 0; m < 256; m++) s_mem[m] <= 8'(m);
        end else if (bus.sbox_clear) begin
            i_idx            <= '0;
            j_idx            <= '0;
            drop_cnt         <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (bus.sbox_wr_en) s_mem[bus.sbox_wr_addr] <= bus.sbox_wr_data;
                DROP1, G1: begin
                    i_idx <= i_inc;
                    si    <= s_at_inc;
                    j_idx <= j_idx + s_at_inc;
                end
                DROP2, G2: begin
                    // When i==j the second write wins and restores the same value.
                    sj           <= s_at_j;
                    s_mem[i_idx] <= s_at_j;
                    s_mem[j_idx] <= si;
                end
                DROP3:   drop_cnt <= drop_cnt + 16'd1;
                WAIT_IN: if (bus.data_in_valid) din_q <= bus.data_in;
                G3: begin
                    data_out_q       <= din_q ^ s_mem[k_idx];
                    data_out_valid_q <= 1'b1;
                end
                HOLD:    if (bus.data_out_ready) data_out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.data_in_ready  = in_rdy;
    assign bus.key_ready      = key_rdy;
    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = data_out_valid_q;
endmodule

// File: tb/tb_rc4_prga_xor.sv
// Randomized self-checking bench for rc4_prga_xor against a plain RC4 model.
module tb_rc4_prga_xor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rc4_prga_xor_if b0();
    rc4_prga_xor_if b3();

    rc4_prga_xor #(.DROP_N(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    rc4_prga_xor #(.DROP_N(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    // The drop instance sees the same stimulus; only its outputs are selected.
    assign b3.sbox_wr_en     = b0.sbox_wr_en;
    assign b3.sbox_wr_addr   = b0.sbox_wr_addr;
    assign b3.sbox_wr_data   = b0.sbox_wr_data;
    assign b3.sbox_done      = b0.sbox_done;
    assign b3.sbox_clear     = b0.sbox_clear;
    assign b3.data_in        = b0.data_in;
    assign b3.data_in_valid  = b0.data_in_valid;
    assign b3.data_out_ready = b0.data_out_ready;

    int checks = 0;
    int errors = 0;
    bit use3 = 1'b0;

    int ms [256];
    int mi, mj;

    logic [7:0] exp_kp [9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] exp_sa [14] = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B,
                                8'h38, 8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic o_rdy(); return use3 ? b3.data_in_ready  : b0.data_in_ready;  endfunction
    function automatic logic o_vld(); return use3 ? b3.data_out_valid : b0.data_out_valid; endfunction
    function automatic logic o_kr();  return use3 ? b3.key_ready      : b0.key_ready;      endfunction
    function automatic logic [7:0] o_dat(); return use3 ? b3.data_out : b0.data_out; endfunction

    task automatic to_q(input string s, output logic [7:0] q[$]);
        q = {};
        for (int n = 0; n < s.len(); n++) q.push_back(s[n]);
    endtask

    // Textbook KSA; an empty key leaves the identity permutation.
    task automatic model_key(input logic [7:0] key[$]);
        int jj, t;
        for (int m = 0; m < 256; m++) ms[m] = m;
        if (key.size() > 0) begin
            jj = 0;
            for (int m = 0; m < 256; m++) begin
                jj = (jj + ms[m] + int'(key[m % key.size()])) % 256;
                t = ms[m]; ms[m] = ms[jj]; ms[jj] = t;
            end
        end
        mi = 0;
        mj = 0;
    endtask

    task automatic model_ks(output logic [7:0] k);
        int t;
        mi = (mi + 1) % 256;
        mj = (mj + ms[mi]) % 256;
        t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
        k = 8'(ms[(ms[mi] + ms[mj]) % 256]);
    endtask

    task automatic clear_pulse();
        b0.sbox_clear = 1'b1;
        @(posedge clk); #1;
        b0.sbox_clear = 1'b0;
    endtask

    task automatic load_key(input logic [7:0] key[$]);
        model_key(key);
        clear_pulse();
        for (int m = 0; m < 256; m++) begin
            b0.sbox_wr_en   = 1'b1;
            b0.sbox_wr_addr = 8'(m);
            b0.sbox_wr_data = 8'(ms[m]);
            b0.sbox_done    = (m == 255);
            @(posedge clk); #1;
        end
        b0.sbox_wr_en = 1'b0;
        b0.sbox_done  = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] din, input int stall, input string tag, input logic [7:0] exp);
        int n, lat;
        b0.data_out_ready = (stall == 0);
        b0.data_in        = din;
        b0.data_in_valid  = 1'b1;
        n = 0;
        while (!o_rdy() && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) chk({tag, "_accept_timeout"}, 1, 0);
        @(posedge clk); #1;
        b0.data_in_valid = 1'b0;
        b0.data_in       = 8'($urandom);
        lat = 0;
        while (!o_vld() && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_data"}, o_dat(), exp);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_valid"}, o_vld(), 1);
            chk({tag, "_stall_data"}, o_dat(), exp);
            chk({tag, "_stall_in_ready"}, o_rdy(), 0);
        end
        b0.data_out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, o_vld(), 0);
    endtask

    initial begin
        logic [7:0] key[$];
        logic [7:0] txt[$];
        logic [7:0] k;
        logic [7:0] d;
        int n;

        rst = 1'b1;
        b0.sbox_wr_en = 1'b0; b0.sbox_wr_addr = '0; b0.sbox_wr_data = '0;
        b0.sbox_done = 1'b0; b0.sbox_clear = 1'b0;
        b0.data_in = '0; b0.data_in_valid = 1'b0; b0.data_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", b0.data_out, 0);
        chk("rst_valid", b0.data_out_valid, 0);
        chk("rst_key_ready", b0.key_ready, 0);
        chk("rst_in_ready", b0.data_in_ready, 0);
        chk("rst_key_ready_d3", b3.key_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer vectors
        to_q("Key", key); to_q("Plaintext", txt);
        load_key(key);
        for (int b = 0; b < 9; b++) xfer(txt[b], 0, "kat_key", exp_kp[b]);

        to_q("Secret", key); to_q("Attack at dawn", txt);
        load_key(key);
        for (int b = 0; b < 14; b++) xfer(txt[b], 0, "kat_secret", exp_sa[b]);

        load_key(key);
        for (int b = 0; b < 14; b++)
            xfer(txt[b], (b == 3) ? 10 : $urandom_range(0, 3), "stalled", exp_sa[b]);

        load_key(key);
        for (int b = 0; b < 14; b++) xfer(exp_sa[b], 0, "decrypt", txt[b]);

        // Drop[3]: fourth keystream byte of "Key" is the first one used
        use3 = 1'b1;
        to_q("Key", key);
        load_key(key);
        n = 0;
        while (!b3.key_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("drop_key_ready_delay", n, 9);
        for (int b = 0; b < 3; b++) model_ks(k);
        model_ks(k);
        xfer(8'h00, 0, "drop_first", 8'h81);
        chk("drop_model_first", k, 8'h81);
        for (int b = 0; b < 4; b++) begin
            model_ks(k);
            xfer(8'h00, 0, "drop_next", k);
        end
        use3 = 1'b0;

        // Reset in the middle of a swap, then identity S-box stream
        load_key(key);
        b0.data_in = 8'h5A; b0.data_in_valid = 1'b1;
        @(posedge clk); #1;
        b0.data_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_data_out", b0.data_out, 0);
        chk("midrst_valid", b0.data_out_valid, 0);
        chk("midrst_key_ready", b0.key_ready, 0);
        chk("midrst_in_ready", b0.data_in_ready, 0);
        rst = 1'b0;
        key = {};
        model_key(key);
        b0.sbox_done = 1'b1;
        @(posedge clk); #1;
        b0.sbox_done = 1'b0;
        for (int b = 0; b < 6; b++) begin
            d = 8'($urandom);
            model_ks(k);
            xfer(d, 0, "identity", d ^ k);
        end

        // Random keys, random stalls, stray load strobes outside EMPTY
        for (int it = 0; it < 3; it++) begin
            key = {};
            n = $urandom_range(1, 16);
            for (int m = 0; m < n; m++) key.push_back(8'($urandom));
            load_key(key);
            for (int b = 0; b < 12; b++) begin
                if ($urandom_range(0, 2) == 0) begin
                    b0.sbox_wr_en   = 1'b1;
                    b0.sbox_wr_addr = 8'($urandom);
                    b0.sbox_wr_data = 8'($urandom);
                    b0.sbox_done    = 1'b1;
                    @(posedge clk); #1;
                    b0.sbox_wr_en = 1'b0;
                    b0.sbox_done  = 1'b0;
                end
                d = 8'($urandom);
                model_ks(k);
                xfer(d, $urandom_range(0, 2), "random", d ^ k);
            end
        end

        // Clear while holding a result; S keeps its (post-swap) contents
        to_q("Key", key);
        load_key(key);
        model_ks(k);
        b0.data_out_ready = 1'b0;
        b0.data_in = 8'h33; b0.data_in_valid = 1'b1;
        @(posedge clk); #1;
        b0.data_in_valid = 1'b0;
        n = 0;
        while (!b0.data_out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("hold_reached", b0.data_out_valid, 1);
        clear_pulse();
        chk("clear_valid", b0.data_out_valid, 0);
        chk("clear_key_ready", b0.key_ready, 0);
        chk("clear_in_ready", b0.data_in_ready, 0);
        b0.data_out_ready = 1'b1;
        mi = 0;
        mj = 0;
        b0.sbox_done = 1'b1;
        @(posedge clk); #1;
        b0.sbox_done = 1'b0;
        for (int b = 0; b < 3; b++) begin
            d = 8'($urandom);
            model_ks(k);
            xfer(d, 0, "after_clear", d ^ k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
